ks_adder_pipe: RTL
==================

// Module: ks_adder_pipe
// PURPOSE
//  Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready streaming handshake.
//  Generalises the fixed 4/8-bit combinational KS adders to any WIDTH.
//  - Prefix levels are split across register stages.
//  - Add/subtract is selectable per operation.
//  - Sits between operand sources and the result consumer on the tt_um_* user datapath.
// PARAMETERS
//  WIDTH            8  operand/sum width in bits; WIDTH >= 2
//  LEVELS_PER_STAGE 1  prefix (BigCircle) levels between pipeline registers; >= 1
//  Derived: L = clog2(WIDTH); NSTAGE = ceil(L/LEVELS_PER_STAGE) + 1 (NSTAGE = 4 at defaults)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a/b/cin/sub valid
//  in_ready   out  1      block can accept an operation this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      1 = A-B, 0 = A+B+cin
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result this cycle
//  sum        out  WIDTH  result
//  cout       out  1      carry-out (add) / not-borrow (sub)
//  ovf        out  1      signed overflow; present only with KS_ADDER_OVF_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits = 0; out_valid = 0; sum = 0; cout = 0; ovf = 0.
//    in_ready = 1 the cycle after release.
//    Data regs need not be reset except the output stage.
//  - Accept: in_valid & in_ready at a rising edge. Stage 0 captures:
//    - g = a & b', p = a ^ b', where b' = sub ? ~b : b
//    - c0 = sub ? 1 : cin; cin is ignored when sub = 1.
//  - Stages 1..NSTAGE-1 each evaluate LEVELS_PER_STAGE KS prefix levels, with span doubling per level: 1, 2, 4, ...
//    - G = Gi | (Pi & Gprev), P = Pi & Pprev.
//    - Positions with no predecessor pass through unchanged (the buffer cell).
//    - c0 is folded in as the generate of a virtual bit -1.
//    - Carries, p and c0 travel with the data.
//  - Final stage registers:
//    - sum[i] = p[i] ^ carry_into[i], with carry_into[0] = c0
//    - cout = group carry out of bit WIDTH-1
//  - Latency: exactly NSTAGE cycles from accept to out_valid with no stall.
//    Throughput: 1 operation per cycle.
//  - Flow control, per stage k (valid bit v[k]):
//    - adv[k] = v[k] & (k == last ? out_ready : (!v[k+1] | adv[k+1]))
//    - Stage k loads when it is empty or advancing.
//    - in_ready = !v[0] | adv[0] (combinational from out_ready).
//    - Bubbles collapse, so up to NSTAGE operations are held while out_ready = 0.
//  - Output stability: while out_valid & !out_ready, sum/cout/ovf stay constant.
//    No result is dropped, duplicated or reordered.
//  - Accept and emit in the same cycle are both legal, and occupancy is unchanged.
//  - Arithmetic is modulo 2^WIDTH; cout = bit WIDTH of the exact (WIDTH+1)-bit result.
//    sub: cout = 1 iff a >= b (unsigned).
//  - in_valid while in_ready = 0: the operation is not taken, and the source holds it.
//  - Reset mid-operation: all in-flight operations are discarded, and no out_valid pulse follows.
// CONFIGURATION
//  KS_ADDER_OVF_EN defined:
//    - port ovf exists, registered alongside sum.
//    - ovf = carry_into[WIDTH-1] ^ cout (two's-complement overflow).
//    - Held stable under stall like sum.
//  KS_ADDER_OVF_EN undefined: port ovf absent; no extra logic or regs; all else identical.
// TESTING (WIDTH=8, LEVELS_PER_STAGE=1, NSTAGE=4)
//  - Reset: rst_n=0 with any inputs -> out_valid=0, sum=8'h00, cout=0. Released -> in_ready=1.
//  - Add wrap: a=8'hFF, b=8'h01, cin=0, sub=0, out_ready=1
//    -> 4 cycles later out_valid=1, sum=8'h00, cout=1.
//    With cin=1 -> sum=8'h01, cout=1.
//  - Subtract: a=8'h05, b=8'h07, sub=1, cin=1 (ignored) -> sum=8'hFE, cout=0.
//    Then a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
//  - Stream and backpressure: 20 random back-to-back ops, out_ready=1 -> one result/cycle in order.
//    out_ready=0 for 10 cycles with in_valid=1 -> exactly 4 further accepts, then in_ready=0.
//    Release -> all results match the reference model, with no loss or duplicates.
//  - Reset mid-flight: 3 ops in pipeline, pulse rst_n low 1 cycle -> no out_valid for any of them.
//    The next op after release arrives with latency 4.
//  - OVF (KS_ADDER_OVF_EN):
//    - 8'h7F+8'h01 -> sum=8'h80, ovf=1
//    - 8'h80-8'h01 -> sum=8'h7F, ovf=1
//    - 8'h10+8'h20 -> ovf=0

Source files
------------

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone add/sub with valid/ready flow control
// Optional signed-overflow output ovf enabled by defining KS_ADDER_OVF_EN.
module ks_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int LEVELS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef KS_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int L = $clog2(WIDTH);
  localparam int NS = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE + 1;
  localparam int NR = NS - 1;

  // Applies the prefix levels owned by pipeline stage s; positions without a predecessor pass through.
  function automatic logic [2*WIDTH-1:0] prefix(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p, input int s);
    logic [WIDTH-1:0] go, po, gq, pq;
    go = g;
    po = p;
    for (int lv = 0; lv < L; lv++) begin
      if (lv / LEVELS_PER_STAGE == s - 1) begin
        gq = go;
        pq = po;
        for (int i = 0; i < WIDTH; i++)
          if (i >= (1 << lv)) begin
            go[i] = gq[i] | (pq[i] & gq[i - (1 << lv)]);
            po[i] = pq[i] & pq[i - (1 << lv)];
          end
      end
    end
    return {go, po};
  endfunction

  logic [NS-1:0] v, vin, ld, adv, en;
  logic [WIDTH-1:0] gr [NR], pr [NR], pp [NR], ng [NR], np [NR], npp [NR];
  logic c0r [NR], nc0 [NR];
  logic [WIDTH-1:0] bx, fg, carry;

  always_comb begin
    vin = {v[NS-2:0], in_valid};
    adv = '0;
    ld = '0;
    adv[NS-1] = v[NS-1] & out_ready;
    ld[NS-1] = !v[NS-1] | adv[NS-1];
    for (int s = NS - 2; s >= 0; s--) begin
      adv[s] = v[s] & ld[s+1];
      ld[s] = !v[s] | adv[s];
    end
    en = ld & vin;
  end

  assign in_ready = ld[0];
  assign out_valid = v[NS-1];

  // c0 is folded into bit 0's generate, so prefix G[i] is the carry out of bit i.
  always_comb begin
    bx = sub ? ~b : b;
    nc0[0] = sub | cin;
    np[0] = a ^ bx;
    npp[0] = np[0];
    ng[0] = (a & bx) | {{(WIDTH-1){1'b0}}, np[0][0] & nc0[0]};
    for (int s = 1; s < NR; s++) begin
      {ng[s], np[s]} = prefix(gr[s-1], pr[s-1], s);
      npp[s] = pp[s-1];
      nc0[s] = c0r[s-1];
    end
    fg = WIDTH'(prefix(gr[NR-1], pr[NR-1], NS - 1) >> WIDTH);
    carry = {fg[WIDTH-2:0], c0r[NR-1]};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else v <= (v & ~ld) | en;

  always_ff @(posedge clk)
    for (int s = 0; s < NR; s++)
      if (en[s]) begin
        gr[s] <= ng[s];
        pr[s] <= np[s];
        pp[s] <= npp[s];
        c0r[s] <= nc0[s];
      end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum <= '0;
      cout <= 1'b0;
`ifdef KS_ADDER_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (en[NS-1]) begin
      sum <= pp[NR-1] ^ carry;
      cout <= fg[WIDTH-1];
`ifdef KS_ADDER_OVF_EN
      ovf <= carry[WIDTH-1] ^ fg[WIDTH-1];
`endif
    end
endmodule
